// File: rtl/fxp_alu_pipe.sv
// Two-stage signed fixed-point ALU (add/sub/mul/mac) with valid/ready on both sides.
// Define FXP_ALU_SAT_EN to clamp out-of-range results; otherwise they wrap.
module fxp_alu_pipe #(
  parameter int ACC_BITS  = 8,
  parameter int FRAC_BITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic                       acc_clr,
  input  logic signed [ACC_BITS-1:0] in1,
  input  logic signed [ACC_BITS-1:0] in2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_BITS-1:0] out_data,
  output logic                       out_ovf
);

  localparam int W  = ACC_BITS;
  localparam int FW = 2 * W + 1;
  localparam logic signed [FW-1:0] MAX_V = $signed({{(FW-W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [FW-1:0] MIN_V = $signed({{(FW-W+1){1'b1}}, {(W-1){1'b0}}});

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_MAC = 2'b11} op_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and a held result stays stable until it is taken.
  logic                s1_valid;
  op_e                 s1_op;
  logic                s1_clr;
  logic signed [W-1:0] s1_in1;
  logic signed [W-1:0] s1_in2;
  logic signed [W-1:0] acc;
  logic                s2_load;

  logic signed [FW-1:0] a_ext, b_ext, acc_ext, prod, prod_sh, full;
  logic signed [W-1:0]  res;
  logic                 ovf;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_load);

  always_comb begin
    a_ext   = {{(FW-W){s1_in1[W-1]}}, s1_in1};
    b_ext   = {{(FW-W){s1_in2[W-1]}}, s1_in2};
    acc_ext = s1_clr ? '0 : {{(FW-W){acc[W-1]}}, acc};
    prod    = a_ext * b_ext;
    // Arithmetic shift floors the product, i.e. truncates toward negative infinity.
    prod_sh = prod >>> FRAC_BITS;
    full    = '0;
    case (s1_op)
      OP_ADD:  full = a_ext + b_ext;
      OP_SUB:  full = a_ext - b_ext;
      OP_MUL:  full = prod_sh;
      OP_MAC:  full = acc_ext + prod_sh;
      default: full = '0;
    endcase
    ovf = (full > MAX_V) || (full < MIN_V);
`ifdef FXP_ALU_SAT_EN
    if (full > MAX_V)      res = MAX_V[W-1:0];
    else if (full < MIN_V) res = MIN_V[W-1:0];
    else                   res = full[W-1:0];
`else
    res = full[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_clr    <= 1'b0;
      s1_in1    <= '0;
      s1_in2    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        s1_op    <= op_e'(op);
        s1_clr   <= acc_clr;
        s1_in1   <= in1;
        s1_in2   <= in2;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_ovf  <= ovf;
          // acc moves with S2 loads, so a mac sitting in S1 always sees the previous mac.
          if (s1_op == OP_MAC) acc <= res;
          else if (s1_clr)     acc <= '0;
        end
      end
    end
  end

endmodule

// File: doc/fxp_alu_pipe.md
FXP_ALU_PIPE -- requirements
Module: fxp_alu_pipe

Interface
REQ-001 The block SHALL have parameter ACC_BITS, default 8: signed two's-complement operand and result width; legal range 4..32.
REQ-002 The block SHALL have parameter FRAC_BITS, default 6: fractional bits of the Q format; legal range 0..ACC_BITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port op, input, 2 bits: operation select (00 add, 01 sub, 10 mul, 11 mac).
REQ-008 The block SHALL have port acc_clr, input, 1 bit: accumulator-clear sideband, qualified by acceptance.
REQ-009 The block SHALL have ports in1 and in2, input, ACC_BITS each, signed operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, ACC_BITS, signed: the result.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: the result did not fit in ACC_BITS.

Function
REQ-014 An operation SHALL be accepted when in_valid && in_ready are both high at a rising clock edge.
REQ-015 A result SHALL be consumed when out_valid && out_ready are both high at a rising clock edge.
REQ-016 The pipeline SHALL have two register stages: S1 registers op, operands and acc_clr; S2 registers the result, and out_data, out_ovf and out_valid are driven from S2.
REQ-017 Latency SHALL be 2 cycles from acceptance to out_valid with out_ready held high; throughput SHALL be 1 operation per cycle.
REQ-018 S2 SHALL load when S2 is empty or out_ready is high; S1 SHALL advance to S2 whenever S2 loads.
REQ-019 in_ready SHALL equal (!S1 valid || S2 loads) and SHALL be low while rst is high.
REQ-020 Under backpressure, out_data and out_ovf SHALL remain stable while out_valid is high and out_ready is low, and no accepted operation SHALL be lost or duplicated.
REQ-021 Add and sub SHALL compute in1 ± in2 at ACC_BITS+1 bits full precision.
REQ-022 Mul SHALL form the 2*ACC_BITS-bit product and arithmetic-shift it right by FRAC_BITS, truncating toward negative infinity.
REQ-023 Mac SHALL compute acc + (in1*in2 >>> FRAC_BITS), where acc is the internal ACC_BITS accumulator; acc SHALL be treated as 0 when that operation's acc_clr is set.
REQ-024 The accumulator SHALL update only when a mac result loads S2, taking the final out_data value; a non-mac operation with acc_clr set SHALL clear acc to 0 when it loads S2.
REQ-025 Back-to-back mac operations SHALL chain without bubbles: each mac uses the acc value produced by the immediately preceding mac.
REQ-026 out_ovf SHALL be 1 exactly when the full-precision result lies outside [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].

Reset
REQ-027 On rst, S1 valid, S2 valid (out_valid), out_data, out_ovf and acc SHALL all be set to 0.
REQ-028 rst asserted mid-operation SHALL discard all in-flight operations, with no result emitted for them.

Configuration
REQ-029 When macro FXP_ALU_SAT_EN is defined, an out-of-range result SHALL clamp to the maximum or minimum representable value, and the accumulator SHALL store the clamped value.
REQ-030 When FXP_ALU_SAT_EN is undefined, an out-of-range result SHALL wrap (keep the low ACC_BITS bits), and out_ovf SHALL still be reported.

Verification (ACC_BITS=8, FRAC_BITS=6)
REQ-031 Add 127+1 -> out_data 127, out_ovf 1 with FXP_ALU_SAT_EN; out_data -128, out_ovf 1 without it.
REQ-032 Mul -128*-128 (-2.0*-2.0) -> out_ovf 1; out_data 127 with sat, 0 with wrap. Mul 32*32 (0.5*0.5) -> out_data 16, out_ovf 0.
REQ-033 Mac stream of 64*32 four times, acc_clr set on the first only -> out_data 32, 64, 96, 127 (sat; wrap gives -128), with out_valid on 4 consecutive cycles.
REQ-034 Backpressure: 5 ops back-to-back, out_ready low for 3 cycles mid-stream -> in_ready drops low, all 5 results arrive in order and unchanged.
REQ-035 rst asserted 1 cycle after acceptance -> out_valid stays 0 and acc reads 0 on the next mac with acc_clr=0.
REQ-036 Sub -1-(-1) with op=01 -> out_data 0, out_ovf 0, 2-cycle latency.
